// File: rtl/jpriority_encoder.sv
// Registered request encoder: latches request lines into a sticky pending set and presents
// one pending line at a time as a binary index until acknowledged.
// Optional round-robin selection: define JPRIORITY_ENCODER_ROUND_ROBIN_EN (default: fixed, lowest index wins).
//
// state   | meaning
// IDLE    | nothing pending, wvalid=0, bos keeps its last value
// PRESENT | bos holds a pending line, wvalid=1, waiting for wack
module jpriority_encoder #(
   parameter int N  = 2,
   parameter int N2 = 4
) (
   input  logic          wclk,
   input  logic          wrst_n,
   input  logic [N2-1:0] bis,
   input  logic          wack,
   output logic [N-1:0]  bos,
   output logic          wvalid,
   output logic          wmore
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N2-1:0] r_pending;
   logic [N2-1:0] w_pending_nxt;
   logic [N2-1:0] w_onehot;
   logic [N2-1:0] w_clr;
   logic [N-1:0]  r_bos;
   logic [N-1:0]  w_bos_nxt;
   logic [N-1:0]  w_start;
   logic [N-1:0]  w_sel;
   logic          w_sel_any;
   logic          w_accept;

   assign w_onehot = {{(N2-1){1'b0}}, 1'b1} << r_bos;
   assign w_accept = (r_state == PRESENT) && wack;
   assign w_clr    = w_accept ? w_onehot : '0;
   // New requests are OR-ed in after the clear so a re-request on the retiring edge survives.
   assign w_pending_nxt = (r_pending & ~w_clr) | bis;

`ifdef JPRIORITY_ENCODER_ROUND_ROBIN_EN
   logic [N-1:0] r_ptr;

   // On an accepting edge the search already starts past the retiring index.
   assign w_start = w_accept ? (r_bos + N'(1)) : r_ptr;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_ptr <= '0;
      end else if (w_accept) begin
         r_ptr <= r_bos + N'(1);
      end
   end
`else
   assign w_start = '0;
`endif

   always_comb begin
      logic [N-1:0] v_idx;
      v_idx     = '0;
      w_sel     = '0;
      w_sel_any = 1'b0;
      // Descending walk so the candidate closest to w_start is written last and wins.
      for (int i = N2 - 1; i >= 0; i--) begin
         v_idx = w_start + N'(i);
         if (w_pending_nxt[v_idx]) begin
            w_sel     = v_idx;
            w_sel_any = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_bos_nxt   = r_bos;
      case (r_state)
         IDLE: begin
            if (w_sel_any) begin
               w_bos_nxt   = w_sel;
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (wack) begin
               if (w_sel_any) begin
                  w_bos_nxt = w_sel;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_bos     <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_bos     <= w_bos_nxt;
      end
   end

   assign bos    = r_bos;
   assign wvalid = (r_state == PRESENT);
   assign wmore  = wvalid && (|(r_pending & ~w_onehot));

endmodule

// File: tb/tb_jpriority_encoder.sv
// Scoreboard bench for jpriority_encoder (N=2): stimulus pushes hand-computed expectations,
// a monitor pops and compares them on each falling edge or on demand.
module tb_jpriority_encoder;

   logic       wclk = 1'b0;
   logic       wrst_n;
   logic [3:0] bis;
   logic       wack;
   logic [1:0] bos;
   logic       wvalid;
   logic       wmore;

   typedef struct {
      string      name;
      logic [1:0] bos;
      logic       v;
      logic       m;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   event e_sample;

   jpriority_encoder #(.N(2), .N2(4)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .bis    (bis),
      .wack   (wack),
      .bos    (bos),
      .wvalid (wvalid),
      .wmore  (wmore)
   );

   always #5 wclk = ~wclk;

   always begin
      exp_t r;
      @(negedge wclk or e_sample);
      if (q.size() > 0) begin
         r = q.pop_front();
         n_checks++;
         if ({bos, wvalid, wmore} !== {r.bos, r.v, r.m}) begin
            n_fail++;
            $display("FAIL %s: got bos=%0d valid=%0b more=%0b, want bos=%0d valid=%0b more=%0b",
                     r.name, bos, wvalid, wmore, r.bos, r.v, r.m);
         end
      end
   end

   task automatic push(input string nm, input logic [1:0] eb, input logic ev, input logic em);
      exp_t r;
      r.name = nm;
      r.bos  = eb;
      r.v    = ev;
      r.m    = em;
      q.push_back(r);
   endtask

   task automatic step(input string nm, input logic [3:0] b, input logic a,
                       input logic [1:0] eb, input logic ev, input logic em);
      bis  = b;
      wack = a;
      @(posedge wclk);
      #1;
      push(nm, eb, ev, em);
   endtask

   // Assert reset between edges and check outputs before any further clock edge.
   task automatic mid_reset(input string nm);
      @(negedge wclk);
      #1;
      wrst_n = 1'b0;
      bis    = 4'b0000;
      wack   = 1'b0;
      #1;
      push(nm, 2'd0, 1'b0, 1'b0);
      -> e_sample;
      @(negedge wclk);
      #1;
      wrst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      wrst_n = 1'b0;
      bis    = 4'b1111;
      wack   = 1'b0;

      // 1. reset with all lines requesting
      @(posedge wclk);
      #1;
      push("rst_hold", 2'd0, 1'b0, 1'b0);
      @(negedge wclk);
      #1;
      wrst_n = 1'b1;
      step("rst_first", 4'b1111, 1'b0, 2'd0, 1'b1, 1'b1);
      step("rst_d1",    4'b0000, 1'b1, 2'd1, 1'b1, 1'b1);
      step("rst_d2",    4'b0000, 1'b1, 2'd2, 1'b1, 1'b1);
      step("rst_d3",    4'b0000, 1'b1, 2'd3, 1'b1, 1'b0);
      step("rst_idle",  4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);

      // 2. pulse capture and hold
      step("hold_0", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) step($sformatf("hold_%0d", i), 4'b0000, 1'b0, 2'd2, 1'b1, 1'b0);
      step("hold_ack", 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);

      // 3. back-to-back retirement
`ifdef JPRIORITY_ENCODER_ROUND_ROBIN_EN
      step("b2b_a",    4'b1010, 1'b1, 2'd3, 1'b1, 1'b1);
      step("b2b_b",    4'b0000, 1'b1, 2'd1, 1'b1, 1'b0);
      step("b2b_idle", 4'b0000, 1'b1, 2'd1, 1'b0, 1'b0);
`else
      step("b2b_a",    4'b1010, 1'b1, 2'd1, 1'b1, 1'b1);
      step("b2b_b",    4'b0000, 1'b1, 2'd3, 1'b1, 1'b0);
      step("b2b_idle", 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);
`endif

      // 4. held requests from a fresh pointer
      mid_reset("rst_pre_held");
      step("held_0", 4'b1111, 1'b1, 2'd0, 1'b1, 1'b1);
      for (int i = 1; i < 5; i++) begin
`ifdef JPRIORITY_ENCODER_ROUND_ROBIN_EN
         step($sformatf("held_%0d", i), 4'b1111, 1'b1, 2'(i % 4), 1'b1, 1'b1);
`else
         step($sformatf("held_%0d", i), 4'b1111, 1'b1, 2'd0, 1'b1, 1'b1);
`endif
      end
      step("drain_1",    4'b0000, 1'b1, 2'd1, 1'b1, 1'b1);
      step("drain_2",    4'b0000, 1'b1, 2'd2, 1'b1, 1'b1);
      step("drain_3",    4'b0000, 1'b1, 2'd3, 1'b1, 1'b0);
      step("drain_idle", 4'b0000, 1'b1, 2'd3, 1'b0, 1'b0);

      // 5. set wins over clear; ack ignored while idle
      step("sw_present", 4'b0100, 1'b0, 2'd2, 1'b1, 1'b0);
      step("sw_again",   4'b0100, 1'b1, 2'd2, 1'b1, 1'b0);
      step("sw_retire",  4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
      step("idle_ack_1", 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
      step("idle_ack_2", 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);

      // 6. reset while presenting with pending=1011
`ifdef JPRIORITY_ENCODER_ROUND_ROBIN_EN
      step("mid_present", 4'b1011, 1'b0, 2'd3, 1'b1, 1'b1);
`else
      step("mid_present", 4'b1011, 1'b0, 2'd0, 1'b1, 1'b1);
`endif
      mid_reset("mid_rst_now");
      step("post_rst_1", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
      step("post_rst_2", 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

      @(negedge wclk);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
